// File: rtl/sobel_frame_packer.sv
// Sobel frame packer: buffers one camera frame of Sobel pixels in a FIFO
// and streams header, pixels and a 16-bit pixel-count trailer to a UART.
module sobel_frame_packer #(
   parameter int            DW      = 8,
   parameter int            FIFO_AW = 9,
   parameter logic [DW-1:0] HDR0    = 8'hAA,
   parameter logic [DW-1:0] HDR1    = 8'h55
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          VSYNC,
   input  logic          pix_valid,
   input  logic [DW-1:0] pix_data,
   input  logic          tx_busy,
   output logic          tx_start,
   output logic [DW-1:0] tx_data,
   output logic          frame_active,
   output logic          overflow,
   output logic [7:0]    skip_cnt
);

   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {
      IDLE, SEND_H0, SEND_H1, STREAM, READ, TRL_LO, TRL_HI, WAIT_TX
   } state_t;

   state_t state, state_d;
   state_t ret, ret_d;

   logic               vsync_q;
   logic               frame_start, frame_end, accept;
   logic               push, pop, full, empty;
   logic               issue;
   logic [DW-1:0]      byte_d;
   logic [15:0]        pix_cnt;
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [DW-1:0]      rd_data;
   logic [DW-1:0]      mem [DEPTH];

   assign frame_start = vsync_q & ~VSYNC;
   assign frame_end   = ~vsync_q & VSYNC;
   assign accept      = frame_start & (state == IDLE);
   assign full        = (count == (FIFO_AW+1)'(DEPTH));
   assign empty       = (count == '0);
   assign push        = pix_valid & frame_active & ~full;

   // vsync_q resets low so a frame already in progress is never adopted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_q      <= 1'b0;
         frame_active <= 1'b0;
         overflow     <= 1'b0;
         skip_cnt     <= 8'd0;
         pix_cnt      <= 16'd0;
      end else begin
         vsync_q <= VSYNC;
         if (accept) begin
            frame_active <= 1'b1;
            overflow     <= 1'b0;
         end else if (frame_end) begin
            frame_active <= 1'b0;
         end
         if (frame_start && state != IDLE)
            skip_cnt <= skip_cnt + 8'd1;
         if (pix_valid && frame_active && full)
            overflow <= 1'b1;
         if (accept)
            pix_cnt <= 16'd0;
         else if (push && pix_cnt != 16'hFFFF)
            pix_cnt <= pix_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (push && !pop)
            count <= count + (FIFO_AW+1)'(1);
         else if (pop && !push)
            count <= count - (FIFO_AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= pix_data;
      if (pop)
         rd_data <= mem[rd_ptr];
   end

   always_comb begin
      state_d = state;
      ret_d   = ret;
      issue   = 1'b0;
      byte_d  = '0;
      pop     = 1'b0;
      unique case (state)
         IDLE:
            if (accept)
               state_d = SEND_H0;
         SEND_H0:
            if (!tx_busy) begin
               issue  = 1'b1;
               byte_d = HDR0;
               ret_d  = SEND_H1;
            end
         SEND_H1:
            if (!tx_busy) begin
               issue  = 1'b1;
               byte_d = HDR1;
               ret_d  = STREAM;
            end
         STREAM:
            if (!empty) begin
               pop     = 1'b1;
               state_d = READ;
            end else if (!frame_active) begin
               state_d = TRL_LO;
            end
         READ:
            if (!tx_busy) begin
               issue  = 1'b1;
               byte_d = rd_data;
               ret_d  = STREAM;
            end
         TRL_LO:
            if (!tx_busy) begin
               issue  = 1'b1;
               byte_d = DW'(pix_cnt[7:0]);
               ret_d  = TRL_HI;
            end
         TRL_HI:
            if (!tx_busy) begin
               issue  = 1'b1;
               byte_d = DW'(pix_cnt[15:8]);
               ret_d  = IDLE;
            end
         // tx_start is high only in the first WAIT_TX cycle
         WAIT_TX:
            if (!tx_start && !tx_busy)
               state_d = ret;
         default:
            state_d = IDLE;
      endcase
      if (issue)
         state_d = WAIT_TX;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ret      <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         state    <= state_d;
         ret      <= ret_d;
         tx_start <= issue;
         if (issue)
            tx_data <= byte_d;
      end
   end

endmodule

// File: doc/sobel_frame_packer.md
SOBEL_FRAME_PACKER -- requirements
Module: sobel_frame_packer

Interface
REQ-001 SHALL have parameter DW, default 8, width of pixel and byte data.
REQ-002 SHALL have parameter FIFO_AW, default 9, log2 of pixel FIFO depth (512 entries).
REQ-003 SHALL have parameter HDR0, default 8'hAA, first frame-header byte.
REQ-004 SHALL have parameter HDR1, default 8'h55, second frame-header byte.
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port VSYNC  input  1  camera frame sync, synchronous to clk, high between frames.
REQ-008 SHALL have port pix_valid  input  1  one-cycle strobe: a Sobel output pixel is present on pix_data.
REQ-009 SHALL have port pix_data  input  DW  Sobel magnitude byte.
REQ-010 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-011 SHALL have port tx_start  output  1  one-cycle request to transmit tx_data.
REQ-012 SHALL have port tx_data  output  DW  byte to transmit, registered.
REQ-013 SHALL have port frame_active  output  1  high while pixels of the current frame are accepted.
REQ-014 SHALL have port overflow  output  1  sticky: a pixel was dropped on FIFO full this frame.
REQ-015 SHALL have port skip_cnt  output  8  frames skipped because the packer was not idle; wraps at 255->0.

Function
REQ-016 SHALL detect frame start as VSYNC 1->0 and frame end as VSYNC 0->1, using a registered copy of VSYNC.
REQ-017 SHALL accept frame start only in state IDLE: set frame_active, clear overflow, clear pixel counter, go to SEND_H0.
REQ-018 SHALL, on frame start outside IDLE, ignore that frame's pixels and increment skip_cnt once.
REQ-019 SHALL clear frame_active on frame end; frame_active SHALL be 0 outside an accepted frame.
REQ-020 SHALL write pix_data into FIFO when pix_valid & frame_active & !full; when full, SHALL drop the pixel and set overflow.
REQ-021 SHALL evaluate full/empty from the registered count only (no same-cycle bypass); simultaneous push and pop SHALL leave count unchanged.
REQ-022 SHALL keep a 16-bit accepted-pixel counter, incremented per FIFO write, saturating at 16'hFFFF.
REQ-023 SHALL use FSM states IDLE, SEND_H0, SEND_H1, STREAM, READ, TRL_LO, TRL_HI, WAIT_TX.
REQ-024 SHALL transmit bytes in order: HDR0, HDR1, FIFO pixels in arrival order, counter[7:0], counter[15:8].
REQ-025 SHALL, in STREAM, pop FIFO when non-empty (synchronous read, data valid next cycle in READ); go to TRL_LO when FIFO empty and frame_active=0.
REQ-026 SHALL issue tx_start only when tx_busy=0, loading tx_data in the same cycle, then enter WAIT_TX.
REQ-027 SHALL, in WAIT_TX, ignore tx_busy for the first cycle, then wait for tx_busy=0 and return to the successor state.
REQ-028 SHALL hold tx_data stable from a tx_start until the next tx_start.
REQ-029 SHALL return to IDLE after TRL_HI is handed to the UART; minimum latency first pixel in -> its tx_start SHALL be 3 cycles once header is sent and tx_busy=0.

Reset
REQ-030 SHALL, on rst=0, asynchronously force: state IDLE, FIFO empty, tx_start=0, tx_data=0, frame_active=0, overflow=0, skip_cnt=0, counter=0.
REQ-031 SHALL, on reset release mid-frame (VSYNC low), not start a frame until a fresh VSYNC 1->0 edge.

Verification
REQ-032 Bench SHALL cover: VSYNC fall, 3 pixels 10,20,30, VSYNC rise, tx_busy=0 -> bytes AA,55,0A,14,1E,03,00 then IDLE.
REQ-033 Bench SHALL cover: 600 pixels with tx_busy held 1 -> 512 stored, overflow=1, trailer 00,02 after release.
REQ-034 Bench SHALL cover: second VSYNC fall while draining -> skip_cnt=1, none of its pixels transmitted.
REQ-035 Bench SHALL cover: tx_busy high 10 cycles after each tx_start -> exactly one tx_start per byte, tx_data stable throughout.
REQ-036 Bench SHALL cover: rst=0 asserted mid-STREAM -> all outputs zero within same cycle, no tx_start until next frame start.
REQ-037 Bench SHALL cover: pix_valid with frame_active=0 -> no FIFO write, counter unchanged.
